// File: rtl/oci_trace_capture.sv
// oci_trace_capture
//
// Collects debug-compressed trace (DCT) frames from NUM_CH CPU OCI blocks.
// A round-robin arbiter feeds one frame per cycle into a shared
// first-word-fall-through FIFO. The host drains the FIFO through a valid/ready
// port. An end-of-test request stops intake, waits for the FIFO to drain and
// then raises a sticky completion flag.
//
// Parameters
//   NUM_CH  number of trace channels (1..8)
//   DCT_W   DCT buffer word width
//   CNT_W   DCT count width
//   DEPTH   FIFO entries (power of two, >= 2)
//   LOSSY   0: back-pressure the sources; 1: never stall, drop on conflict/full
//
// Ports
//   clk, reset_n    clock (rising edge) and asynchronous active-low reset
//   ch_valid        per-channel frame valid
//   ch_buffer       packed dct_buffer, channel i at [i*DCT_W +: DCT_W]
//   ch_count        packed dct_count, channel i at [i*CNT_W +: CNT_W]
//   ch_ready        per-channel accept (combinational, 0 while in reset)
//   rd_valid        FIFO head valid
//   rd_data         head dct_buffer
//   rd_count        head dct_count
//   rd_ch           head source channel
//   rd_ready        host pop
//   test_ending     flush request, sampled every cycle
//   test_has_ended  sticky: flush complete
//   overflow        sticky: at least one frame dropped (LOSSY=1 only)
//   drop_count      saturating dropped-frame counter
//   fill_level      current FIFO occupancy

module oci_trace_capture #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DCT_W  = 30,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned DEPTH  = 16,
    parameter bit          LOSSY  = 1'b0,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned FILL_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       ch_valid,
    input  logic [NUM_CH*DCT_W-1:0] ch_buffer,
    input  logic [NUM_CH*CNT_W-1:0] ch_count,
    output logic [NUM_CH-1:0]       ch_ready,
    output logic                    rd_valid,
    output logic [DCT_W-1:0]        rd_data,
    output logic [CNT_W-1:0]        rd_count,
    output logic [CH_W-1:0]         rd_ch,
    input  logic                    rd_ready,
    input  logic                    test_ending,
    output logic                    test_has_ended,
    output logic                    overflow,
    output logic [15:0]             drop_count,
    output logic [FILL_W-1:0]       fill_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = DCT_W + CNT_W + CH_W;

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StEnded
    } state_e;

    state_e            state_q;
    logic              ended_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [FILL_W-1:0] fill_q;
    logic [EW-1:0]     mem_q [DEPTH];
    logic [CH_W-1:0]   rr_ptr_q;
    logic [15:0]       drop_q;
    logic              ovf_q;

    logic              run;
    logic              full;
    logic              push;
    logic              pop;
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] zero_cnt;
    logic              found;
    logic [CH_W-1:0]   winner;
    logic [EW-1:0]     wr_entry;
    logic [EW-1:0]     head;
    logic [15:0]       drop_inc;
    logic [16:0]       drop_sum;

    // Intake is only open in RUN; reset gating keeps ch_ready low while reset_n=0.
    assign run  = (state_q == StRun) && reset_n;
    assign full = (fill_q == FILL_W'(DEPTH));

    // A frame with a zero count carries no trace and is never stored.
    always_comb begin
        elig     = '0;
        zero_cnt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            elig[i]     = ch_valid[i] && (ch_count[i*CNT_W +: CNT_W] != '0);
            zero_cnt[i] = ch_valid[i] && (ch_count[i*CNT_W +: CNT_W] == '0);
        end
    end

    // Round-robin search: first eligible channel at or after rr_ptr, with wrap.
    always_comb begin
        int unsigned idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && elig[idx[CH_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        ch_ready = '0;
        if (run) begin
            if (LOSSY) begin
                ch_ready = '1;
            end else begin
                ch_ready = zero_cnt;
                if (found && !full) begin
                    ch_ready[winner] = 1'b1;
                end
            end
        end
    end

    // Full is judged on the pre-pop occupancy, so a pop never frees a slot
    // for a push in the same cycle.
    assign push = run && found && !full;
    assign pop  = rd_valid && rd_ready;

    // In lossy mode every eligible frame not stored this cycle is lost.
    always_comb begin
        drop_inc = '0;
        if (LOSSY && run) begin
            drop_inc = 16'($countones(elig)) - 16'(push);
        end
    end

    assign drop_sum = {1'b0, drop_q} + {1'b0, drop_inc};

    assign wr_entry = {ch_buffer[32'(winner)*DCT_W +: DCT_W],
                       ch_count[32'(winner)*CNT_W +: CNT_W],
                       winner};

    // Storage array carries no reset; the read side masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            rr_ptr_q <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                rr_ptr_q <= (32'(winner) == NUM_CH - 1) ? '0 : winner + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            fill_q <= fill_q + FILL_W'(push) - FILL_W'(pop);
            if (drop_inc != '0) begin
                drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
                ovf_q  <= 1'b1;
            end
        end
    end

    // End-of-test sequencing. FLUSH checks emptiness at the edge itself, so an
    // already-empty FIFO ends one edge after the request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StRun;
            ended_q <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (test_ending) begin
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    if (fill_q == '0) begin
                        state_q <= StEnded;
                        ended_q <= 1'b1;
                    end
                end
                StEnded: begin
                    state_q <= StEnded;
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign rd_valid = (fill_q != '0);
    assign rd_data  = rd_valid ? head[EW-1 -: DCT_W]   : '0;
    assign rd_count = rd_valid ? head[CH_W +: CNT_W]   : '0;
    assign rd_ch    = rd_valid ? head[CH_W-1:0]        : '0;

    assign test_has_ended = ended_q;
    assign overflow       = ovf_q;
    assign drop_count     = drop_q;
    assign fill_level     = fill_q;

endmodule

// File: tb/tb_oci_trace_capture.sv
// Bench for oci_trace_capture: one lossless and one lossy instance share the
// same stimulus. A cycle-level reference model predicts ch_ready, occupancy,
// drops and end-of-test status, and pushes each accepted frame into a
// per-instance expectation queue that a separate monitor drains on pops.

module tb_oci_trace_capture;

    localparam int NCH   = 4;
    localparam int DW    = 30;
    localparam int CW    = 4;
    localparam int DEPTH = 16;
    localparam int EW    = DW + CW + 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NCH-1:0]    ch_valid;
    logic [NCH*DW-1:0] ch_buffer;
    logic [NCH*CW-1:0] ch_count;
    logic              rd_ready;
    logic              test_ending;

    logic [NCH-1:0]    ch_ready [2];
    logic              rd_valid [2];
    logic [DW-1:0]     rd_data  [2];
    logic [CW-1:0]     rd_count [2];
    logic [1:0]        rd_ch    [2];
    logic              ended    [2];
    logic              ovf      [2];
    logic [15:0]       dcnt     [2];
    logic [4:0]        fill     [2];

    int n_cmp;
    int n_bad;

    // Reference model state, index 0 = lossless, 1 = lossy.
    int m_state [2];  // 0 run, 1 flush, 2 ended
    int m_rr    [2];
    int m_fill  [2];
    int m_drops [2];
    bit m_ovf   [2];
    logic [EW-1:0] exp_q0 [$];
    logic [EW-1:0] exp_q1 [$];

    always #5 clk = ~clk;

    oci_trace_capture #(
        .NUM_CH(NCH), .DCT_W(DW), .CNT_W(CW), .DEPTH(DEPTH), .LOSSY(1'b0)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .ch_valid(ch_valid), .ch_buffer(ch_buffer),
        .ch_count(ch_count), .ch_ready(ch_ready[0]), .rd_valid(rd_valid[0]),
        .rd_data(rd_data[0]), .rd_count(rd_count[0]), .rd_ch(rd_ch[0]),
        .rd_ready(rd_ready), .test_ending(test_ending), .test_has_ended(ended[0]),
        .overflow(ovf[0]), .drop_count(dcnt[0]), .fill_level(fill[0])
    );

    oci_trace_capture #(
        .NUM_CH(NCH), .DCT_W(DW), .CNT_W(CW), .DEPTH(DEPTH), .LOSSY(1'b1)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .ch_valid(ch_valid), .ch_buffer(ch_buffer),
        .ch_count(ch_count), .ch_ready(ch_ready[1]), .rd_valid(rd_valid[1]),
        .rd_data(rd_data[1]), .rd_count(rd_count[1]), .rd_ch(rd_ch[1]),
        .rd_ready(rd_ready), .test_ending(test_ending), .test_has_ended(ended[1]),
        .overflow(ovf[1]), .drop_count(dcnt[1]), .fill_level(fill[1])
    );

    task automatic chk(input string name, input int m, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, m, act, exp);
        end
    endtask

    task automatic pop_exp(input int m, output bit ok, output logic [EW-1:0] e);
        ok = 1'b0;
        e  = '0;
        if (m == 0) begin
            if (exp_q0.size() > 0) begin
                e  = exp_q0.pop_front();
                ok = 1'b1;
            end
        end else begin
            if (exp_q1.size() > 0) begin
                e  = exp_q1.pop_front();
                ok = 1'b1;
            end
        end
    endtask

    // Monitor: every head presented while the host accepts must be the oldest
    // frame the model accepted for that instance.
    always @(negedge clk) begin : mon
        logic [EW-1:0] got;
        logic [EW-1:0] e;
        bit ok;
        if (reset_n && rd_ready) begin
            for (int m = 0; m < 2; m++) begin
                if (rd_valid[m]) begin
                    got = {rd_data[m], rd_count[m], rd_ch[m]};
                    pop_exp(m, ok, e);
                    if (!ok) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rd_entry dut%0d: got %0h expected no entry", m, got);
                    end else begin
                        chk("rd_entry", m, 64'(got), 64'(e));
                    end
                end
            end
        end
    end

    function automatic logic [CW-1:0] cnt_of(input int c);
        return ch_count[c*CW +: CW];
    endfunction

    // One clock: predict and check at the negedge, advance the model at the
    // posedge, return 1 time unit later so the caller can drive new inputs.
    task automatic cycle();
        logic [NCH-1:0] er;
        int  win [2];
        bit  pu  [2];
        bit  po  [2];
        int  dr  [2];
        int  ne;
        bit  run;
        bit  full;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            ne     = 0;
            win[m] = -1;
            for (int k = 0; k < NCH; k++) begin
                int c = (m_rr[m] + k) % NCH;
                if (ch_valid[c] && cnt_of(c) != 0) begin
                    ne++;
                    if (win[m] < 0) win[m] = c;
                end
            end
            run  = (m_state[m] == 0);
            full = (m_fill[m] == DEPTH);
            er   = '0;
            if (run) begin
                if (m == 1) begin
                    er = '1;
                end else begin
                    for (int c = 0; c < NCH; c++) begin
                        if (ch_valid[c] && cnt_of(c) == 0) er[c] = 1'b1;
                    end
                    if (win[m] >= 0 && !full) er[win[m]] = 1'b1;
                end
            end
            pu[m] = run && (win[m] >= 0) && !full;
            po[m] = rd_ready && (m_fill[m] > 0);
            dr[m] = (m == 1 && run) ? ne - int'(pu[m]) : 0;
            chk("ch_ready",       m, 64'(ch_ready[m]), 64'(er));
            chk("fill_level",     m, 64'(fill[m]),     64'(m_fill[m]));
            chk("rd_valid",       m, 64'(rd_valid[m]), 64'(m_fill[m] > 0));
            chk("drop_count",     m, 64'(dcnt[m]),     64'(m_drops[m]));
            chk("overflow",       m, 64'(ovf[m]),      64'(m_ovf[m]));
            chk("test_has_ended", m, 64'(ended[m]),    64'(m_state[m] == 2));
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (pu[m]) begin
                logic [EW-1:0] ent;
                ent = {ch_buffer[win[m]*DW +: DW], cnt_of(win[m]), 2'(win[m])};
                if (m == 0) exp_q0.push_back(ent);
                else        exp_q1.push_back(ent);
                m_rr[m] = (win[m] + 1) % NCH;
            end
            if (m_state[m] == 0 && test_ending)     m_state[m] = 1;
            else if (m_state[m] == 1 && m_fill[m] == 0) m_state[m] = 2;
            m_fill[m] = m_fill[m] + int'(pu[m]) - int'(po[m]);
            m_drops[m] = (m_drops[m] + dr[m] > 65535) ? 65535 : m_drops[m] + dr[m];
            if (dr[m] > 0) m_ovf[m] = 1'b1;
        end
        #1;
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        ch_valid = '1;
        for (int c = 0; c < NCH; c++) ch_count[c*CW +: CW] = 4'd5;
        reset_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("rst_ch_ready",   m, 64'(ch_ready[m]), 64'(0));
            chk("rst_rd_valid",   m, 64'(rd_valid[m]), 64'(0));
            chk("rst_rd_fields",  m, 64'({rd_data[m], rd_count[m], rd_ch[m]}), 64'(0));
            chk("rst_ended",      m, 64'(ended[m]),    64'(0));
            chk("rst_overflow",   m, 64'(ovf[m]),      64'(0));
            chk("rst_drop_count", m, 64'(dcnt[m]),     64'(0));
            chk("rst_fill_level", m, 64'(fill[m]),     64'(0));
            m_state[m] = 0;
            m_rr[m]    = 0;
            m_fill[m]  = 0;
            m_drops[m] = 0;
            m_ovf[m]   = 1'b0;
        end
        exp_q0.delete();
        exp_q1.delete();
        @(posedge clk);
        #1;
        reset_n     = 1'b1;
        ch_valid    = '0;
        test_ending = 1'b0;
    endtask

    // Random buffers; counts random with zero allowed when allow_zero is set.
    task automatic rand_frames(input bit allow_zero);
        for (int c = 0; c < NCH; c++) begin
            ch_buffer[c*DW +: DW] = DW'($urandom);
            ch_count[c*CW +: CW]  = allow_zero ? CW'($urandom_range(0, 15))
                                               : CW'($urandom_range(1, 15));
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        reset_n     = 1'b0;
        ch_valid    = '0;
        ch_buffer   = '0;
        ch_count    = '0;
        rd_ready    = 1'b0;
        test_ending = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Fairness: all channels valid, count 3, host always ready.
        rd_ready = 1'b1;
        repeat (24) begin
            rand_frames(1'b0);
            ch_count = {NCH{4'd3}};
            ch_valid = '1;
            cycle();
        end

        // Random traffic with zero counts and host stalls.
        repeat (400) begin
            rand_frames(1'b1);
            ch_valid = NCH'($urandom);
            rd_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Back-pressure: channel 2 streams into a stalled host.
        do_reset();
        rd_ready = 1'b0;
        repeat (20) begin
            rand_frames(1'b0);
            ch_valid = 4'b0100;
            cycle();
        end
        chk("bp_full_fill", 0, 64'(fill[0]), 64'(16));
        chk("bp_ready_low", 0, 64'(ch_ready[0][2]), 64'(0));
        rd_ready = 1'b1;
        ch_valid = '0;
        repeat (20) cycle();

        // Lossy drop with the FIFO full, then drop-counter saturation.
        do_reset();
        rd_ready = 1'b0;
        repeat (16) begin
            rand_frames(1'b0);
            ch_valid = 4'b0001;
            cycle();
        end
        rand_frames(1'b0);
        ch_valid = 4'b0011;
        cycle();
        ch_valid = '0;
        cycle();
        chk("lossy_drop_count", 1, 64'(dcnt[1]), 64'(2));
        chk("lossy_overflow",   1, 64'(ovf[1]),  64'(1));
        rand_frames(1'b0);
        ch_valid = '1;
        repeat (17500) cycle();
        chk("drop_saturate", 1, 64'(dcnt[1]), 64'(16'hFFFF));

        // Zero count frames are accepted and discarded.
        do_reset();
        rd_ready = 1'b0;
        repeat (5) begin
            rand_frames(1'b0);
            ch_count[1*CW +: CW] = '0;
            ch_valid = 4'b0010;
            #1;
            chk("zero_ready", 0, 64'(ch_ready[0][1]), 64'(1));
            cycle();
        end
        chk("zero_fill",  0, 64'(fill[0]), 64'(0));
        chk("zero_drops", 1, 64'(dcnt[1]), 64'(0));

        // Flush: queue 5 frames, pulse test_ending while frames keep coming.
        do_reset();
        rd_ready = 1'b0;
        repeat (5) begin
            rand_frames(1'b0);
            ch_valid = 4'b1000;
            cycle();
        end
        rand_frames(1'b0);
        ch_valid    = '1;
        test_ending = 1'b1;
        rd_ready    = 1'b1;
        cycle();
        test_ending = 1'b0;
        repeat (12) begin
            rand_frames(1'b0);
            ch_valid = NCH'($urandom);
            cycle();
        end
        chk("flush_ended", 0, 64'(ended[0]), 64'(1));
        test_ending = 1'b1;
        repeat (3) cycle();
        chk("ended_sticky", 0, 64'(ended[0]), 64'(1));
        chk("ended_sticky", 1, 64'(ended[1]), 64'(1));
        test_ending = 1'b0;

        // Reset mid-flush with 7 frames pending.
        do_reset();
        rd_ready = 1'b0;
        repeat (7) begin
            rand_frames(1'b0);
            ch_valid = 4'b0001;
            cycle();
        end
        ch_valid    = '0;
        test_ending = 1'b1;
        cycle();
        test_ending = 1'b0;
        repeat (2) cycle();
        chk("preflush_fill", 0, 64'(fill[0]), 64'(7));
        do_reset();
        rand_frames(1'b0);
        ch_valid = 4'b0001;
        #1;
        chk("run_after_reset", 0, 64'(ch_ready[0]), 64'(4'b0001));
        chk("run_after_reset", 1, 64'(ch_ready[1]), 64'(4'b1111));
        cycle();
        ch_valid = '0;
        rd_ready = 1'b1;
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/oci_trace_capture.md
# oci_trace_capture

Parametrised multi-core successor to the per-CPU OCI trace test-bench hook. Collects debug-compressed trace (DCT) frames from NUM_CH CPU OCI blocks through a round-robin arbiter and stores them in a shared first-word-fall-through FIFO. A host-side valid/ready port drains the FIFO. An end-of-test handshake flushes the FIFO and then reports completion. The block sits between the CPU OCI instances and the platform debug/readout logic.

## Interface
- NUM_CH, 4, number of trace channels (1..8)
- DCT_W, 30, DCT buffer word width
- CNT_W, 4, DCT count width
- DEPTH, 16, FIFO entries (power of two, ≥2)
- LOSSY, 0, 0 = back-pressure sources; 1 = never stall, drop on conflict/full
- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- ch_valid  in  NUM_CH  per-channel frame valid
- ch_buffer  in  NUM_CH*DCT_W  packed dct_buffer, channel i at [i*DCT_W +: DCT_W]
- ch_count  in  NUM_CH*CNT_W  packed dct_count, channel i at [i*CNT_W +: CNT_W]
- ch_ready  out  NUM_CH  per-channel accept (combinational)
- rd_valid  out  1  FIFO head valid
- rd_data  out  DCT_W  head dct_buffer
- rd_count  out  CNT_W  head dct_count
- rd_ch  out  max(1,$clog2(NUM_CH))  head source channel
- rd_ready  in  1  host pop
- test_ending  in  1  start flush (level or pulse, sampled each cycle)
- test_has_ended  out  1  sticky: flush complete
- overflow  out  1  sticky: at least one frame dropped (LOSSY=1 only)
- drop_count  out  16  saturating dropped-frame counter
- fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- States: RUN (reset), FLUSH, ENDED. The state is encoded internally.
- Transitions:
  - RUN→FLUSH when test_ending=1.
  - FLUSH→ENDED when the FIFO is empty at a clock edge, including empty on entry.
  - ENDED holds until reset.
  - test_has_ended=1 in ENDED only.
- Eligibility: channel i is eligible when ch_valid[i]=1 and its count≠0.
  - A valid frame with count=0 gets ch_ready[i]=1 in RUN. It is discarded, not stored, and not counted as a drop.
- Arbitration: search starts at rr_ptr and takes the first eligible channel in ascending order with wrap.
  - After a grant, rr_ptr = winner+1 mod NUM_CH.
  - rr_ptr is unchanged when nothing is granted.
- LOSSY=0 in RUN: only the winner gets ch_ready=1, and only when the FIFO is not full. Ungranted sources hold their frame.
- LOSSY=1 in RUN: ch_ready=all ones.
  - The winner is stored if the FIFO is not full.
  - Every other eligible channel that cycle is dropped, and so is the winner when the FIFO is full.
  - drop_count adds the number dropped that cycle and saturates at 16'hFFFF.
  - overflow is set on any drop.
- FLUSH/ENDED: ch_ready=0 in both modes.
- Write entry fields: {buffer, count, channel index}.
- Pop: a pop occurs on rd_valid & rd_ready. rd_valid = (fill_level≠0) in all states.
- fill_level updates each cycle by +push −pop.
- Simultaneous push and pop:
  - Not full: both occur and fill_level is unchanged.
  - Full: push is blocked because full is evaluated before the pop.

## Timing
- Reset values: ch_ready=0 (combinational; it is forced 0 while reset_n=0), rd_valid=0, rd_data=0, rd_count=0, rd_ch=0, test_has_ended=0, overflow=0, drop_count=0, fill_level=0, rr_ptr=0, state RUN.
- Write-to-read latency: a frame accepted at edge N appears on rd_* after edge N, so rd_valid can rise in cycle N+1.
- ch_ready depends combinationally on ch_valid, ch_count, rr_ptr, full and state. There is no path from rd_ready to ch_ready.
- The test_ending sampled at edge N forces ch_ready=0 from cycle N+1. A push in the same cycle as test_ending is still accepted.
- test_has_ended rises on the edge after the final pop empties the FIFO.
- Reset mid-operation discards FIFO contents and clears all counters, flags and state immediately.
- Pointers wrap modulo DEPTH, and full is indicated by fill_level==DEPTH.

## Test plan
- Fairness: NUM_CH=4 with all channels valid continuously, count=3, rd_ready=1. Required: rd_ch sequence is 0,1,2,3,0,…, one entry per cycle, fill_level ≤1.
- Back-pressure: LOSSY=0, DEPTH=16, rd_ready=0, channel 2 streaming. Required: exactly 16 accepts, then ch_ready[2]=0 and fill_level=16. Setting rd_ready=1 drains the data in order with no loss.
- Lossy drop: LOSSY=1, FIFO full, channels 0 and 1 valid for 1 cycle. Required: drop_count=2, overflow=1. Saturation check: forcing 70000 drops gives drop_count=16'hFFFF.
- Zero count: ch_valid[1]=1, count=0. Required: ch_ready[1]=1, fill_level stays 0, drop_count stays 0.
- Flush: 5 entries queued, test_ending pulse, rd_ready=1. Required: no further accepts, 5 pops, then test_has_ended=1 one edge after the last pop. The flag stays set when test_ending is reasserted.
- Reset mid-flush: deassert reset_n with 7 entries in FLUSH. Required: all outputs return to their reset values asynchronously, and the block is in RUN after release.
